// File: rtl/uart_pkg.sv
// Shared UART definitions: shifter state encoding and bit-timing helper,
// common to the transmitter and receiver so both agree on line timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last count of each period with tick.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Period counter; wraps on the last count so the next period starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && !clear && (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NUM_BITS data bits LSB first, STOP_BITS stop
// bits, with a one-entry holding register for gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 9600,
  parameter int NUM_BITS  = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W = $clog2(NUM_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);
  localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e         state_r;
  logic [NUM_BITS-1:0] shift_r;
  logic [NUM_BITS-1:0] hold_r;
  logic                hold_full_r;
  logic [IDX_W-1:0]    idx_r;
  logic [0:0]          stop_idx_r;
  logic                tx_r;
  logic                busy_r;
  logic                done_r;

  logic                tick_s;
  logic                accept_s;
  logic                frame_end_s;
  logic                direct_load_s;
  logic [NUM_BITS-1:0] shift_next_s;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (state_r == IDLE),
    .enable(state_r != IDLE),
    .tick  (tick_s)
  );

  assign accept_s      = i_valid && !hold_full_r;
  assign frame_end_s   = (state_r == STOP) && tick_s && (stop_idx_r == LAST_STOP);
  assign direct_load_s = accept_s && ((state_r == IDLE) || frame_end_s);
  assign shift_next_s  = shift_r >> 1'b1;

  // Shifter FSM, holding register and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      idx_r       <= '0;
      stop_idx_r  <= 1'b0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept_s && !direct_load_s) begin
        hold_r      <= i_data;
        hold_full_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= START;
            shift_r <= i_data;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_r <= DATA;
            idx_r   <= '0;
            tx_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r <= shift_next_s;
            idx_r   <= idx_r + 1'b1;
            if (idx_r == LAST_IDX) begin
              state_r    <= STOP;
              stop_idx_r <= 1'b0;
              tx_r       <= 1'b1;
            end else begin
              tx_r <= shift_next_s[0];
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (stop_idx_r == LAST_STOP) begin
              done_r <= 1'b1;
              // Chain the next frame straight into START so the line never idles.
              if (hold_full_r) begin
                state_r     <= START;
                shift_r     <= hold_r;
                hold_full_r <= 1'b0;
                tx_r        <= 1'b0;
              end else if (accept_s) begin
                state_r <= START;
                shift_r <= i_data;
                tx_r    <= 1'b0;
              end else begin
                state_r <= IDLE;
                tx_r    <= 1'b1;
                busy_r  <= 1'b0;
              end
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ~hold_full_r;
  assign o_tx    = tx_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: the transmit partner of the existing uart_rx receiver.
- Frame format: 8N1 by default (start bit 0, NUM_BITS data bits LSB first, STOP_BITS stop bits at 1), driven on o_tx.
- Parallel bytes arrive on a valid/ready handshake. A one-entry holding register allows back-to-back frames with no idle gap.
- Sits between bt_control command logic and the Bluetooth module RX pin.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- NUM_BITS, 8, data bits per frame (1..16).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- CLKS_PER_BIT (derived, not overridable), CLK_FREQ/BAUD (integer divide), clocks each line bit is held.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  NUM_BITS  byte to send; sampled when i_valid && o_ready.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  block can accept a byte this cycle.
- o_tx  output  1  serial line, idles high.
- o_busy  output  1  a frame is currently on the line.
- o_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async assert, sync use after deassert):
  - o_tx=1, o_busy=0, o_done=0, o_ready=1.
  - Holding register empty; shifter in IDLE; counters 0.
  - Reset mid-frame aborts the frame immediately; o_tx returns to 1 asynchronously.
- Registered outputs: o_tx, o_busy and o_done come from flops. o_ready = ~hold_full (combinational from a flop).
- Accept: handshake occurs at an edge where i_valid=1 and o_ready=1.
  - If the shifter is IDLE, or finishing its last stop bit on that same edge, the byte loads straight into the shifter.
  - Otherwise it loads into the holding register; hold_full=1.
- Latency: o_tx goes low (start bit) on the same edge as the accepting handshake when the shifter is idle.
- State machine (shifter), each line bit held exactly CLKS_PER_BIT cycles by a bit-period counter 0..CLKS_PER_BIT-1:
  - IDLE: o_tx=1, o_busy=0. On load -> START.
  - START: o_tx=0. At period end -> DATA, bit index 0.
  - DATA: o_tx=shift[0]. At period end, shift right and increment index. After the NUM_BITS-th bit -> STOP.
  - STOP: o_tx=1. Repeat for STOP_BITS periods. At the end of the last period:
    - o_done=1 for that single cycle.
    - If hold_full: move the holding register into the shifter, clear hold_full, go to START (no idle cycle).
    - Else if the handshake is accepted on that edge: load i_data, go to START.
    - Else -> IDLE.
- o_busy = 1 in START, DATA and STOP.
- Frame length: (1+NUM_BITS+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Holding register full: o_ready=0, and i_valid is ignored (no overwrite, no loss).
- Handshake and holding drain on the same edge cannot occur, because o_ready=0 while the holding register is full.
- i_data only needs to be stable on the accepting edge.
- Counter width: clog2(CLKS_PER_BIT). Bit index width: clog2(NUM_BITS+1). Shift register width: NUM_BITS.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - A clks_per_bit(CLK_FREQ, BAUD) constant function, so uart_rx and uart_tx agree on timing.
- One natural sub-module, uart_baud_cnt: bit-period counter.
  - Inputs: clear, enable.
  - Output: a tick at count CLKS_PER_BIT-1.
  - Shareable with a future uart_rx rework.

Test Plan:
All tests use CLK_FREQ=12000000, BAUD=1000000 (CLKS_PER_BIT=12).
- Single byte: send 0xA5 while idle.
  - o_tx low on the accept edge for 12 cycles, then bits 1,0,1,0,0,1,0,1 at 12 cycles each, then high for 12 cycles.
  - o_done pulses once at cycle 120; o_busy high for exactly 120 cycles.
- Loopback: uart_tx o_tx feeds uart_rx i_data; send 0x00, 0xFF, 0x3C.
  - uart_rx o_done asserts with o_data matching each byte.
- Back-to-back:
  - Hold i_valid high with 0x11 then 0x22; o_ready drops after the second accept.
  - Second start bit begins on the cycle after the first stop bit ends; no idle cycle.
  - o_ready returns high on that edge.
- Backpressure: offer a third byte 0x33 while the holding register is full.
  - Not accepted until o_ready=1.
  - Line carries 0x11, 0x22, 0x33 in order; no corruption.
- Reset mid-frame: assert i_rst_n=0 during DATA bit 3 of 0x5A.
  - o_tx=1, o_busy=0, o_ready=1 immediately.
  - After release, sending 0xC3 produces a clean 120-cycle frame.
- Stop bits: rerun with STOP_BITS=2 and send 0x81.
  - Stop level held high for 24 cycles; frame length 132 cycles.
